// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR control sequencer: phase lengths,
// state encoding and the coefficient RAM address layout {bank, idx}.
package fir_ctrl_pkg;

    localparam int NUM_TAPS  = 10;  // taps per bank, also words per bank load
    localparam int NUM_BANKS = 4;
    localparam int RUN_LEN   = 13;  // busy cycles of one filter pass
    localparam int TAIL_LEN  = 2;   // flag-high cycles after the last write
    localparam int GAP_LEN   = 3;   // flag-low cycles before the load completes

    localparam int CNT_W  = 4;                   // shared phase counter width
    localparam int BANK_W = $clog2(NUM_BANKS);   // bank field of the address

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        UPD_FLAG = 3'd2,
        UPD_WR   = 3'd3,
        UPD_TAIL = 3'd4,
        UPD_GAP  = 3'd5
    } seqState_t;

    // Coefficient RAM address: bank in the upper bits, tap index below.
    function automatic logic [BANK_W+CNT_W-1:0] ramAddr(
        input logic [BANK_W-1:0] bank,
        input logic [CNT_W-1:0]  idx
    );
        return {bank, idx};
    endfunction

endpackage

// File: rtl/fir_ctrl_seq_if.sv
// Bundle of everything fir_ctrl_seq exchanges with its surroundings except
// clock and reset: sample/bank controls, the load request, the coefficient
// stream and the control/RAM signals that drive ReConf_FirFilter.
//
// Coefficient stream handshake: a beat transfers on a rising clock edge where
// iCoeffValid and oCoeffReady are both high. oCoeffReady depends only on the
// sequencer phase, never on iCoeffValid; the source may raise or drop
// iCoeffValid in any cycle and must keep iCoeffData stable while valid is
// high and ready is low.
interface fir_ctrl_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    import fir_ctrl_pkg::*;

    // Inputs to the sequencer
    logic              iEnSample600k;
    logic [1:0]        iBankSel;
    logic              iUpdReq;
    logic [1:0]        iUpdBank;
    logic              iCoeffValid;
    logic [DATA_W-1:0] iCoeffData;

    // Sequencer status
    logic              oCoeffReady;
    logic              oUpdAck;
    logic              oUpdDone;
    logic              oOverrun;
    logic              oBusy;

    // Filter control / RAM signals
    logic              oCoeffUpdateFlag;
    logic              oCsnRam;
    logic              oWrnRam;
    logic              oEnMul;
    logic              oEnAddAcc;
    logic [ADDR_W-1:0] oAddrRam;
    logic [DATA_W-1:0] oWtDtRam;

    // Current FSM state, for observation only
    seqState_t         dbgState;

    // The sequencer side
    modport master (
        input  iEnSample600k, iBankSel, iUpdReq, iUpdBank, iCoeffValid, iCoeffData,
        output oCoeffReady, oUpdAck, oUpdDone, oOverrun, oBusy,
        output oCoeffUpdateFlag, oCsnRam, oWrnRam, oEnMul, oEnAddAcc,
        output oAddrRam, oWtDtRam, dbgState
    );

    // The environment side: sample timing, load requester, coefficient source
    modport slave (
        output iEnSample600k, iBankSel, iUpdReq, iUpdBank, iCoeffValid, iCoeffData,
        input  oCoeffReady, oUpdAck, oUpdDone, oOverrun, oBusy,
        input  oCoeffUpdateFlag, oCsnRam, oWrnRam, oEnMul, oEnAddAcc,
        input  oAddrRam, oWtDtRam, dbgState
    );

endinterface

// File: rtl/fir_ctrl_seq.sv
// Control sequencer for ReConf_FirFilter. On each sample strobe it runs one
// 10-tap pass (RAM read, multiply enable, accumulate enable) over a selected
// coefficient bank; on request it loads one bank through the filter's
// coefficient-update protocol (flag, writes, tail, gap). All outputs are
// registered.
module fir_ctrl_seq #(
    parameter int NUM_TAPS = fir_ctrl_pkg::NUM_TAPS,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16
) (
    input  logic           iClk12M,
    input  logic           iRst,
    fir_ctrl_seq_if.master bus
);
    import fir_ctrl_pkg::*;

    // Counter values that mark phase boundaries
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TAP_LAST  = CNT_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] MUL_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] ACC_FIRST = CNT_W'(2);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    seqState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;      // shared by RUN / UPD_WR / UPD_TAIL / UPD_GAP
    logic [BANK_W-1:0] bank, bankNext;    // bank latched for the current pass or load

    logic strobe;    // sample strobe this cycle
    logic runEnd;    // last cycle of a filter pass
    logic gapEnd;    // last cycle of a load
    logic decide;    // cycle in which a new strobe or load request may be accepted
    logic beat;      // coefficient word transferred this cycle

    // Next values of the registered outputs
    logic              readyD, ackD, doneD, overrunD, busyD;
    logic              flagD, csnD, wrnD, enMulD, enAddAccD;
    logic [ADDR_W-1:0] addrD;
    logic [DATA_W-1:0] dataD;

    assign strobe = bus.iEnSample600k;
    assign runEnd = (state == RUN)     && (cnt == RUN_LAST);
    assign gapEnd = (state == UPD_GAP) && (cnt == GAP_LAST);
    // The edge that finishes a pass or a load behaves exactly like IDLE, so a
    // strobe or request landing there is served without a lost cycle.
    assign decide = (state == IDLE) || runEnd || gapEnd;
    // oCoeffReady is registered as "next state is UPD_WR", so it is high in
    // exactly the cycles where state is UPD_WR.
    assign beat   = (state == UPD_WR) && bus.iCoeffValid;

    assign bus.dbgState = state;

    // State, counter, bank and output registers
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state                <= IDLE;
            cnt                  <= '0;
            bank                 <= '0;
            bus.oCoeffReady      <= 1'b0;
            bus.oUpdAck          <= 1'b0;
            bus.oUpdDone         <= 1'b0;
            bus.oOverrun         <= 1'b0;
            bus.oBusy            <= 1'b0;
            bus.oCoeffUpdateFlag <= 1'b0;
            bus.oCsnRam          <= 1'b1;
            bus.oWrnRam          <= 1'b1;
            bus.oEnMul           <= 1'b0;
            bus.oEnAddAcc        <= 1'b0;
            bus.oAddrRam         <= '0;
            bus.oWtDtRam         <= '0;
        end else begin
            state                <= stateNext;
            cnt                  <= cntNext;
            bank                 <= bankNext;
            bus.oCoeffReady      <= readyD;
            bus.oUpdAck          <= ackD;
            bus.oUpdDone         <= doneD;
            bus.oOverrun         <= overrunD;
            bus.oBusy            <= busyD;
            bus.oCoeffUpdateFlag <= flagD;
            bus.oCsnRam          <= csnD;
            bus.oWrnRam          <= wrnD;
            bus.oEnMul           <= enMulD;
            bus.oEnAddAcc        <= enAddAccD;
            bus.oAddrRam         <= addrD;
            bus.oWtDtRam         <= dataD;
        end
    end

    // Next state: phase progression, then strobe/request arbitration at decision points
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        bankNext  = bank;

        case (state)
            IDLE: begin
                cntNext = '0;
            end
            RUN: begin
                cntNext = cnt + CNT_ONE;
            end
            UPD_FLAG: begin
                stateNext = UPD_WR;
                cntNext   = '0;
            end
            UPD_WR: begin
                if (beat) begin
                    if (cnt == TAP_LAST) begin
                        stateNext = UPD_TAIL;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + CNT_ONE;
                    end
                end
            end
            UPD_TAIL: begin
                if (cnt == TAIL_LAST) begin
                    stateNext = UPD_GAP;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end
            UPD_GAP: begin
                cntNext = cnt + CNT_ONE;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase

        // Sample strobe has priority; a simultaneous request stays pending.
        if (decide) begin
            cntNext = '0;
            if (strobe) begin
                stateNext = RUN;
                bankNext  = bus.iBankSel;
            end else if (bus.iUpdReq) begin
                stateNext = UPD_FLAG;
                bankNext  = bus.iUpdBank;
            end else begin
                stateNext = IDLE;
            end
        end
    end

    // Output decode: filter controls from the current phase, status from the decision
    always_comb begin
        flagD     = 1'b0;
        csnD      = 1'b1;
        wrnD      = 1'b1;
        enMulD    = 1'b0;
        enAddAccD = 1'b0;
        addrD     = ADDR_W'(ramAddr(bank, CNT_W'(0)));
        dataD     = '0;

        ackD      = decide && !strobe && bus.iUpdReq;
        doneD     = gapEnd;
        overrunD  = strobe && !decide;
        busyD     = (stateNext != IDLE);
        readyD    = (stateNext == UPD_WR);

        case (state)
            RUN: begin
                // Read taps 0..9; multiply trails the read by one cycle and
                // accumulate trails it by two.
                if (cnt <= TAP_LAST) begin
                    csnD  = 1'b0;
                    addrD = ADDR_W'(ramAddr(bank, cnt));
                end
                enMulD    = (cnt >= MUL_FIRST) && (cnt <= MUL_LAST);
                enAddAccD = (cnt >= ACC_FIRST) && (cnt <= ACC_LAST);
            end
            UPD_FLAG: begin
                flagD = 1'b1;
            end
            UPD_WR: begin
                flagD = 1'b1;
                if (beat) begin
                    csnD  = 1'b0;
                    wrnD  = 1'b0;
                    addrD = ADDR_W'(ramAddr(bank, cnt));
                    dataD = bus.iCoeffData;
                end else begin
                    // Stall: keep the address where it was, no RAM access.
                    addrD = bus.oAddrRam;
                end
            end
            UPD_TAIL: begin
                flagD = 1'b1;
                addrD = '0;
            end
            default: begin
            end
        endcase
    end

endmodule
